// File: rtl/commit_sched_if.sv
// commit_sched_if: bundles the ROB-head, register-file write, LSB store
// handshake and flush/redirect signals of the commit scheduler.
//   master : the commit scheduler (drives rob_pop, st_commit_req, write_*,
//            clear_flag, redirect_*, commit_cnt; samples head_*, st_commit_ack)
//   slave  : the surrounding ROB / register file / LSB
interface commit_sched_if #(
    parameter int unsigned ROB_ID_W = 3
);
    logic                head_valid;
    logic                head_ready;
    logic [1:0]          head_type;
    logic [4:0]          head_rd;
    logic [ROB_ID_W-1:0] head_rob_id;
    logic [31:0]         head_val;
    logic                head_mispred;
    logic [31:0]         head_target;
    logic                rob_pop;
    logic                st_commit_req;
    logic                st_commit_ack;
    logic [4:0]          write_reg_id;
    logic [ROB_ID_W-1:0] write_ROB_id;
    logic [31:0]         write_val;
    logic                clear_flag;
    logic                redirect_valid;
    logic [31:0]         redirect_pc;
    logic [31:0]         commit_cnt;

    modport master (
        input  head_valid, head_ready, head_type, head_rd, head_rob_id, head_val,
               head_mispred, head_target, st_commit_ack,
        output rob_pop, st_commit_req, write_reg_id, write_ROB_id, write_val,
               clear_flag, redirect_valid, redirect_pc, commit_cnt
    );

    modport slave (
        output head_valid, head_ready, head_type, head_rd, head_rob_id, head_val,
               head_mispred, head_target, st_commit_ack,
        input  rob_pop, st_commit_req, write_reg_id, write_ROB_id, write_val,
               clear_flag, redirect_valid, redirect_pc, commit_cnt
    );
endinterface

// File: rtl/commit_sched.sv
// commit_sched: in-order commit sequencer between the ROB head, the register
// file write port and the LSB.
//   clk_in  : system clock
//   rst_in  : asynchronous active-low reset
//   rdy_in  : global ready; low pauses the block (state held, no pop, no write)
//   bus     : commit_sched_if.master (ROB head in, rob_pop, store handshake,
//             register write, clear_flag flush, PC redirect, commit_cnt)
// Optional: define COMMIT_SCHED_PERF_EN to build the commit_cnt counter;
// otherwise commit_cnt is tied to 0.
module commit_sched #(
    parameter int unsigned ROB_ID_W     = 3,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic             clk_in,
    input logic             rst_in,
    input logic             rdy_in,
    commit_sched_if.master  bus
);
    localparam logic [1:0] TypeStore  = 2'd1;
    localparam logic [1:0] TypeBranch = 2'd2;
    localparam logic [3:0] FlushLoad  = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWaitSt, StFlush} state_e;

    state_e              state_q, state_d;
    logic [3:0]          flush_cnt_q, flush_cnt_d;
    logic                st_req_q, st_req_d;
    logic [4:0]          wr_reg_q, wr_reg_d;
    logic [ROB_ID_W-1:0] wr_rob_q, wr_rob_d;
    logic [31:0]         wr_val_q, wr_val_d;
    logic                clear_q, clear_d;
    logic                redir_valid_q, redir_valid_d;
    logic [31:0]         redir_pc_q, redir_pc_d;
    logic                rob_pop;

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        st_req_d      = st_req_q;
        // Write port is a one-cycle strobe; also zero while paused.
        wr_reg_d      = 5'd0;
        wr_rob_d      = wr_rob_q;
        wr_val_d      = wr_val_q;
        clear_d       = clear_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        rob_pop       = 1'b0;
        if (rdy_in) begin
            redir_valid_d = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.head_valid && bus.head_ready) begin
                        if (bus.head_type == TypeStore) begin
                            st_req_d = 1'b1;
                            state_d  = StWaitSt;
                        end else begin
                            rob_pop  = 1'b1;
                            wr_reg_d = bus.head_rd;
                            wr_rob_d = bus.head_rob_id;
                            wr_val_d = bus.head_val;
                            if (bus.head_type == TypeBranch && bus.head_mispred) begin
                                redir_valid_d = 1'b1;
                                redir_pc_d    = bus.head_target;
                                clear_d       = 1'b1;
                                flush_cnt_d   = FlushLoad;
                                state_d       = StFlush;
                            end
                        end
                    end
                end
                StWaitSt: begin
                    if (bus.st_commit_ack) begin
                        rob_pop  = 1'b1;
                        st_req_d = 1'b0;
                        state_d  = StIdle;
                    end
                end
                StFlush: begin
                    if (flush_cnt_q == 4'd0) begin
                        clear_d = 1'b0;
                        state_d = StIdle;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 4'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= StIdle;
            flush_cnt_q   <= 4'd0;
            st_req_q      <= 1'b0;
            wr_reg_q      <= 5'd0;
            wr_rob_q      <= '0;
            wr_val_q      <= 32'd0;
            clear_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            st_req_q      <= st_req_d;
            wr_reg_q      <= wr_reg_d;
            wr_rob_q      <= wr_rob_d;
            wr_val_q      <= wr_val_d;
            clear_q       <= clear_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign bus.rob_pop        = rob_pop;
    assign bus.st_commit_req  = st_req_q;
    assign bus.write_reg_id   = wr_reg_q;
    assign bus.write_ROB_id   = wr_rob_q;
    assign bus.write_val      = wr_val_q;
    assign bus.clear_flag     = clear_q;
    assign bus.redirect_valid = redir_valid_q;
    assign bus.redirect_pc    = redir_pc_q;

`ifdef COMMIT_SCHED_PERF_EN
    logic [31:0] commit_cnt_q, commit_cnt_d;

    always_comb begin
        commit_cnt_d = commit_cnt_q + 32'(rob_pop);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            commit_cnt_q <= 32'd0;
        end else begin
            commit_cnt_q <= commit_cnt_d;
        end
    end

    assign bus.commit_cnt = commit_cnt_q;
`else
    assign bus.commit_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_commit_sched.sv
// tb_commit_sched: scoreboard bench for commit_sched. The stimulus process
// predicts each cycle's control outputs plus register-write and redirect
// events from the commit rules; a negedge monitor pops and compares them.
module tb_commit_sched;
    localparam int unsigned Fc = 2;
`ifdef COMMIT_SCHED_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    typedef struct {
        bit          pop;
        bit          req;
        bit          clear;
        bit          redir;
        logic [31:0] cnt;
    } ctrl_t;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [2:0]  id;
        logic [31:0] val;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
    } rd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b0;

    commit_sched_if #(.ROB_ID_W(3)) bus ();

    commit_sched #(.ROB_ID_W(3), .FLUSH_CYCLES(Fc)) u_dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    bit redir_prev = 1'b0;
    ctrl_t ctrl_q[$];
    wr_t   wr_q[$];
    rd_t   rdr_q[$];

    // Reference model state: store outstanding, flush window, redirect level.
    bit          m_req;
    int          req_rise;
    int          fl_start;
    int          fl_end;
    bit          m_redir;
    logic [31:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_req = 1'b0;
        req_rise = 0;
        fl_start = 1;
        fl_end = 0;
        m_redir = 1'b0;
        m_cnt = 32'd0;
    endtask

    task automatic idle_inputs();
        bus.head_valid = 1'b0;
        bus.head_ready = 1'b0;
        bus.head_type = 2'd0;
        bus.head_rd = 5'd0;
        bus.head_rob_id = 3'd0;
        bus.head_val = 32'd0;
        bus.head_mispred = 1'b0;
        bus.head_target = 32'd0;
        bus.st_commit_ack = 1'b0;
    endtask

    // Async reset; outputs must drop without waiting for a clock edge.
    task automatic apply_reset();
        mon_en = 1'b0;
        ctrl_q.delete();
        wr_q.delete();
        rdr_q.delete();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req", 32'(bus.st_commit_req), 32'd0);
        check("rst_clear", 32'(bus.clear_flag), 32'd0);
        check("rst_wr", 32'(bus.write_reg_id), 32'd0);
        check("rst_redir", 32'(bus.redirect_valid), 32'd0);
        check("rst_cnt", bus.commit_cnt, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step(input bit r, input bit v, input bit hr, input logic [1:0] t,
                        input logic [4:0] rd, input logic [2:0] id, input logic [31:0] val,
                        input bit mis, input logic [31:0] tgt, input bit ack);
        ctrl_t e;
        bit busy;
        bit pop;
        bit nredir;
        @(posedge clk);
        #1;
        cyc++;
        rdy = r;
        bus.head_valid = v;
        bus.head_ready = hr;
        bus.head_type = t;
        bus.head_rd = rd;
        bus.head_rob_id = id;
        bus.head_val = val;
        bus.head_mispred = mis;
        bus.head_target = tgt;
        bus.st_commit_ack = ack;
        busy = (cyc >= fl_start) && (cyc <= fl_end);
        e.req = m_req;
        e.clear = busy;
        e.redir = m_redir;
        e.cnt = m_cnt;
        pop = 1'b0;
        nredir = m_redir;
        if (!r) begin
            if (busy) fl_end++;
        end else begin
            nredir = 1'b0;
            if (busy) begin
                pop = 1'b0;
            end else if (m_req) begin
                if (ack) begin
                    pop = 1'b1;
                    m_req = 1'b0;
                end
            end else if (v && hr) begin
                if (t == 2'd1) begin
                    m_req = 1'b1;
                    req_rise = cyc + 1;
                end else begin
                    pop = 1'b1;
                    if (rd != 5'd0) wr_q.push_back('{cyc + 1, rd, id, val});
                    if (t == 2'd2 && mis) begin
                        nredir = 1'b1;
                        rdr_q.push_back('{cyc + 1, tgt});
                        fl_start = cyc + 1;
                        fl_end = cyc + int'(Fc);
                    end
                end
            end
        end
        e.pop = pop;
        ctrl_q.push_back(e);
        m_redir = nredir;
        if (pop && PerfEn) m_cnt = m_cnt + 32'd1;
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [2:0] id, input logic [31:0] val);
        step(1, 1, 1, 2'd0, rd, id, val, 0, 0, 0);
    endtask

    task automatic rand_step();
        bit ack_ok;
        ack_ok = m_req && ((cyc + 1) > req_rise);
        step(($urandom_range(0, 7) != 0), ($urandom_range(0, 4) != 0),
             ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 2)),
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 2) == 0), $urandom,
             ack_ok && ($urandom_range(0, 1) == 1));
    endtask

    always @(negedge clk) begin
        ctrl_t e;
        wr_t w;
        rd_t d;
        if (mon_en) begin
            if (ctrl_q.size() == 0) begin
                check("ctrl_underflow", 32'd1, 32'd0);
            end else begin
                e = ctrl_q.pop_front();
                check("rob_pop", 32'(bus.rob_pop), 32'(e.pop));
                check("st_commit_req", 32'(bus.st_commit_req), 32'(e.req));
                check("clear_flag", 32'(bus.clear_flag), 32'(e.clear));
                check("redirect_valid", 32'(bus.redirect_valid), 32'(e.redir));
                check("commit_cnt", bus.commit_cnt, e.cnt);
            end
            while (wr_q.size() != 0 && wr_q[0].cyc < cyc) begin
                w = wr_q.pop_front();
                check("write_missing", 32'd0, 32'(w.rd));
            end
            if (bus.write_reg_id != 5'd0) begin
                if (wr_q.size() == 0) begin
                    check("write_extra", 32'(bus.write_reg_id), 32'd0);
                end else begin
                    w = wr_q.pop_front();
                    check("write_cycle", cyc, w.cyc);
                    check("write_reg_id", 32'(bus.write_reg_id), 32'(w.rd));
                    check("write_ROB_id", 32'(bus.write_ROB_id), 32'(w.id));
                    check("write_val", bus.write_val, w.val);
                end
            end
            while (rdr_q.size() != 0 && rdr_q[0].cyc < cyc) begin
                d = rdr_q.pop_front();
                check("redirect_missing", 32'd0, d.pc);
            end
            if (bus.redirect_valid && !redir_prev) begin
                if (rdr_q.size() == 0) begin
                    check("redirect_extra", bus.redirect_pc, 32'd0);
                end else begin
                    d = rdr_q.pop_front();
                    check("redirect_cycle", cyc, d.cyc);
                    check("redirect_pc", bus.redirect_pc, d.pc);
                end
            end
        end
        redir_prev = bus.redirect_valid;
    end

    initial begin
        idle_inputs();
        model_reset();
        apply_reset();
        idle(1);
        // Single ALU commit.
        alu(5'd5, 3'd2, 32'h1234);
        idle(2);
        // Back-to-back ALU commits.
        alu(5'd1, 3'd3, 32'h11);
        alu(5'd2, 3'd4, 32'h22);
        alu(5'd3, 3'd5, 32'h33);
        idle(2);
        // Store acked on the fourth request cycle.
        step(1, 1, 1, 2'd1, 5'd7, 3'd6, 32'h55, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 2'd1, 5'd7, 3'd6, 32'h55, 0, 0, 0);
        step(1, 1, 1, 2'd1, 5'd7, 3'd6, 32'h55, 0, 0, 1);
        idle(1);
        // Mispredicted JAL, then a ready ALU head held through the flush.
        step(1, 1, 1, 2'd2, 5'd1, 3'd7, 32'h104, 1, 32'h200, 0);
        for (int i = 0; i < 3; i++) alu(5'd9, 3'd0, 32'h99);
        idle(2);
        // rd=0 commit, then a not-ready head.
        alu(5'd0, 3'd1, 32'hdead);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 2'd0, 5'd4, 3'd2, 32'h44, 0, 0, 0);
        alu(5'd4, 3'd2, 32'h44);
        idle(1);
        // Pause in WAIT_ST with ack high.
        step(1, 1, 1, 2'd1, 5'd0, 3'd3, 32'h0, 0, 0, 0);
        step(1, 1, 1, 2'd1, 5'd0, 3'd3, 32'h0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 2'd1, 5'd0, 3'd3, 32'h0, 0, 0, 1);
        step(1, 1, 1, 2'd1, 5'd0, 3'd3, 32'h0, 0, 0, 1);
        idle(2);
        // Reset mid-WAIT_ST and mid-FLUSH.
        step(1, 1, 1, 2'd1, 5'd0, 3'd4, 32'h0, 0, 0, 0);
        step(1, 1, 1, 2'd1, 5'd0, 3'd4, 32'h0, 0, 0, 0);
        apply_reset();
        idle(1);
        step(1, 1, 1, 2'd2, 5'd2, 3'd5, 32'h300, 1, 32'h400, 0);
        idle(1);
        apply_reset();
        idle(1);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) rand_step();
        while (m_req) step(1, 0, 0, 0, 0, 0, 0, 0, 0, (cyc + 1) > req_rise);
        idle(Fc + 3);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("write_q_drained", wr_q.size(), 32'd0);
        check("redirect_q_drained", rdr_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
